// File: rtl/audio_dac_serializer.sv
// Stereo audio DAC serializer: takes left/right sample pairs through a
// one-deep holding register and shifts them out MSB-first on AUD_DACDAT.
// The word clock AUD_DACLRCK is derived from the same position counter.
// Everything runs on the falling edge of AUD_BCLK. Every output except
// in_ready is registered, so a bit period shows what the edge that started
// it decided. Left-justified and I2S framing are both supported.
module audio_dac_serializer #(
  parameter int SAMPLE_W      = 16,
  parameter int SLOT_W        = 32,
  parameter bit LEFT_HIGH     = 1'b1,
  parameter bit UNDERRUN_ZERO = 1'b1
) (
  input  logic                       AUD_BCLK,
  input  logic                       reset_n,
  input  logic signed [SAMPLE_W-1:0] in_l,
  input  logic signed [SAMPLE_W-1:0] in_r,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       fmt,
  input  logic                       mute,
  output logic                       AUD_DACDAT,
  output logic                       AUD_DACLRCK,
  output logic                       frame_start,
  output logic                       underrun
);

  localparam int FRAME_LEN = 2 * SLOT_W;
  localparam int POS_W     = $clog2(FRAME_LEN);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0] SLOT_LEN = POS_W'(SLOT_W);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  // Reject parameter sets the slot layout cannot represent.
  if (SAMPLE_W < 8 || SAMPLE_W > 32) begin : g_bad_sample_w
    $error("audio_dac_serializer: SAMPLE_W must be in 8..32");
  end
  if (SLOT_W < SAMPLE_W || SLOT_W > 64) begin : g_bad_slot_w
    $error("audio_dac_serializer: SLOT_W must satisfy SAMPLE_W <= SLOT_W <= 64");
  end

  // Serial bit for slot offset k. The slot word is the sample left-aligned
  // in SLOT_W bits with zero padding below. A zero is prepended above the
  // MSB so the I2S one-bit delay becomes a shift of the index by one:
  // k=0 then picks the prepended zero, and the sample LSB falls off the end
  // whenever the slot has no padding.
  function automatic logic slot_bit(
    input logic signed [SAMPLE_W-1:0] sample,
    input logic        [POS_W-1:0]    k,
    input logic                       i2s
  );
    logic [SLOT_W:0] ext;
    int              idx;
    logic            b;
    ext = '0;
    ext[SLOT_W-1 -: SAMPLE_W] = sample;
    idx = SLOT_W - int'(k) - (i2s ? 0 : 1);
    b = 1'b0;
    for (int i = 0; i <= SLOT_W; i++) begin
      if (i == idx) b = ext[i];
    end
    return b;
  endfunction

  // Control and frame state
  logic [POS_W-1:0]           pos;
  logic                       hold_full;
  logic                       first_frame;
  logic                       fmt_frame;
  logic                       mute_frame;
  logic signed [SAMPLE_W-1:0] act_l;
  logic signed [SAMPLE_W-1:0] act_r;

  // Holding register contents (data only, qualified by hold_full)
  logic signed [SAMPLE_W-1:0] hold_l;
  logic signed [SAMPLE_W-1:0] hold_r;

  // Next-state values for the falling edge
  logic [POS_W-1:0]           pos_nxt;
  logic [POS_W-1:0]           k_nxt;
  logic                       frame_start_nxt;
  logic                       accept;
  logic                       hold_full_nxt;
  logic                       fmt_nxt;
  logic                       mute_nxt;
  logic                       left_slot_nxt;
  logic                       underrun_nxt;
  logic                       dat_nxt;
  logic                       lrck_nxt;
  logic signed [SAMPLE_W-1:0] act_l_nxt;
  logic signed [SAMPLE_W-1:0] act_r_nxt;
  logic signed [SAMPLE_W-1:0] sample_nxt;

  // The holding register is free unless full; nothing is taken while in reset.
  assign in_ready = reset_n & ~hold_full;
  assign accept   = in_valid & in_ready;

  // Work out the next bit period: position, frame load, and the bit it emits.
  always_comb begin
    frame_start_nxt = (pos == POS_LAST);
    pos_nxt         = frame_start_nxt ? '0 : pos + POS_ONE;
    left_slot_nxt   = (pos_nxt < SLOT_LEN);
    k_nxt           = left_slot_nxt ? pos_nxt : pos_nxt - SLOT_LEN;

    // Format and mute are latched per frame so mid-frame changes wait for p0.
    fmt_nxt  = frame_start_nxt ? fmt  : fmt_frame;
    mute_nxt = frame_start_nxt ? mute : mute_frame;

    // The frame takes the pair held before this edge; an accept on the
    // same edge only refills the holding register.
    act_l_nxt    = act_l;
    act_r_nxt    = act_r;
    underrun_nxt = 1'b0;
    if (frame_start_nxt) begin
      if (hold_full) begin
        act_l_nxt = hold_l;
        act_r_nxt = hold_r;
      end else begin
        underrun_nxt = ~first_frame;
        if (UNDERRUN_ZERO) begin
          act_l_nxt = '0;
          act_r_nxt = '0;
        end
      end
    end

    if (accept) begin
      hold_full_nxt = 1'b1;
    end else if (frame_start_nxt) begin
      hold_full_nxt = 1'b0;
    end else begin
      hold_full_nxt = hold_full;
    end

    sample_nxt = mute_nxt ? '0 : (left_slot_nxt ? act_l_nxt : act_r_nxt);
    dat_nxt    = slot_bit(sample_nxt, k_nxt, fmt_nxt);
    lrck_nxt   = left_slot_nxt ? LEFT_HIGH : ~LEFT_HIGH;
  end

  // Falling-edge state and registered outputs; reset aborts the frame at once.
  always_ff @(negedge AUD_BCLK) begin
    if (!reset_n) begin
      pos         <= POS_LAST;
      hold_full   <= 1'b0;
      first_frame <= 1'b1;
      fmt_frame   <= 1'b0;
      mute_frame  <= 1'b0;
      act_l       <= '0;
      act_r       <= '0;
      AUD_DACDAT  <= 1'b0;
      AUD_DACLRCK <= ~LEFT_HIGH;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      pos         <= pos_nxt;
      hold_full   <= hold_full_nxt;
      first_frame <= 1'b0;
      fmt_frame   <= fmt_nxt;
      mute_frame  <= mute_nxt;
      act_l       <= act_l_nxt;
      act_r       <= act_r_nxt;
      AUD_DACDAT  <= dat_nxt;
      AUD_DACLRCK <= lrck_nxt;
      frame_start <= frame_start_nxt;
      underrun    <= underrun_nxt;
    end
  end

  // Capture an offered pair; validity is tracked by hold_full alone.
  always_ff @(negedge AUD_BCLK) begin
    if (accept) begin
      hold_l <= in_l;
      hold_r <= in_r;
    end
  end

endmodule

// File: doc/audio_dac_serializer.md
AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, giving sample width in bits (legal range 8..32).
REQ-002 SHALL have parameter SLOT_W, default 32, giving BCLKs per channel slot (legal when SLOT_W >= SAMPLE_W and SLOT_W <= 64).
REQ-003 SHALL have parameter LEFT_HIGH, default 1, giving the AUD_DACLRCK level that marks the left slot.
REQ-004 SHALL have parameter UNDERRUN_ZERO, default 1: on underrun, 1 = send zeros, 0 = repeat the last pair.
REQ-005 SHALL have port AUD_BCLK, input, width 1: the single clock; all state updates on its falling edge.
REQ-006 SHALL have port reset_n, input, width 1: reset, synchronous and active-low.
REQ-007 SHALL have port in_l, input, width SAMPLE_W: signed left sample.
REQ-008 SHALL have port in_r, input, width SAMPLE_W: signed right sample.
REQ-009 SHALL have port in_valid, input, width 1: in_l/in_r pair offered.
REQ-010 SHALL have port in_ready, output, width 1: holding register can accept a pair.
REQ-011 SHALL have port fmt, input, width 1: 0 = left-justified, 1 = I2S (one-BCLK data delay).
REQ-012 SHALL have port mute, input, width 1: force zero output.
REQ-013 SHALL have port AUD_DACDAT, output, width 1: serial data, MSB first.
REQ-014 SHALL have port AUD_DACLRCK, output, width 1: word clock.
REQ-015 SHALL have port frame_start, output, width 1: high during bit period 0 of each frame.
REQ-016 SHALL have port underrun, output, width 1: one-cycle pulse when a frame starts with no pair held.

Function
REQ-017 SHALL keep a position counter p running 0..2*SLOT_W-1 and wrapping to 0, with one frame = 2*SLOT_W BCLKs.
REQ-018 SHALL register all outputs so each bit period p holds the values set by the falling edge that produced p.
REQ-019 SHALL drive AUD_DACLRCK = LEFT_HIGH for p < SLOT_W and ~LEFT_HIGH otherwise, in both formats.
REQ-020 SHALL form the slot word as the sample in the top SAMPLE_W bits, zero-padded below; let k = p mod SLOT_W.
REQ-021 SHALL, with fmt=0, drive AUD_DACDAT = slot_word[SLOT_W-1-k].
REQ-022 SHALL, with fmt=1, drive AUD_DACDAT = 0 at k=0 and slot_word[SLOT_W-k] for k>=1; when SLOT_W == SAMPLE_W the sample LSB is dropped.
REQ-023 SHALL keep a one-pair holding register with hold_full flag and drive in_ready = ~hold_full (0 while reset_n=0).
REQ-024 SHALL accept a pair when in_valid && in_ready, storing in_l/in_r and setting hold_full.
REQ-025 SHALL, at the edge that makes p=0 (frame start), load the active pair from holding and clear hold_full.
REQ-026 SHALL, on an accept and frame start at the same edge, use the old holding contents for the frame, store the new pair, and keep hold_full=1.
REQ-027 SHALL, if hold_full=0 at frame start, pulse underrun for that bit period and set the active pair to zero (UNDERRUN_ZERO=1) or leave it unchanged (UNDERRUN_ZERO=0).
REQ-028 SHALL sample fmt and mute only at frame start; mute=1 sends an all-zero frame but still consumes the held pair.
REQ-029 SHALL never change AUD_DACDAT/AUD_DACLRCK mid-frame because of the handshake.

Reset
REQ-030 SHALL, while reset_n=0 at a falling edge, set p=2*SLOT_W-1, hold_full=0, active pair=0, last pair=0, AUD_DACDAT=0, AUD_DACLRCK=~LEFT_HIGH, frame_start=0, underrun=0.
REQ-031 SHALL make the first edge with reset_n=1 a frame start, suppressing underrun for that first frame only.
REQ-032 SHALL, on reset mid-frame, abort the frame immediately and discard the held pair.

Verification (SAMPLE_W=16, SLOT_W=32, LEFT_HIGH=1 unless stated)
REQ-033 SHALL be verified as: fmt=0, pair L=0xA5F0 R=0x1234 accepted before frame -> p0..15 DACDAT=A5F0 MSB-first, p16..31=0, p32..47=1234, LRCK=1 for p0..31.
REQ-034 SHALL be verified as: fmt=1 with the same pair -> p0=0, p1..16=A5F0, p33..48=1234, LRCK unchanged from fmt=0.
REQ-035 SHALL be verified as: no pair offered for a frame -> underrun=1 at p0, DACDAT all 0; with UNDERRUN_ZERO=0, previous pair repeated.
REQ-036 SHALL be verified as: in_valid held high continuously -> in_ready low except one cycle per frame, exactly one pair consumed per 64 BCLKs, no underrun.
REQ-037 SHALL be verified as: reset_n low at p=40 -> next edge gives DACDAT=0, LRCK=0, in_ready=0; release -> frame_start at the first edge, underrun=0.
REQ-038 SHALL be verified as: mute=1 at frame start with a pair held -> zero frame, hold_full cleared; fmt toggled mid-frame -> no effect until next p0.
